// File: rtl/lsu_pkg.sv
// Shared mem_op encoding (also used by decode), FSM state type and small field helpers.
package lsu_pkg;

  // mem_op[4:3] operation
  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_RD  = 2'b01;
  localparam logic [1:0] OP_WR  = 2'b10;

  // mem_op[1:0] access length (2'b11 is reserved and behaves as a no-op)
  localparam logic [1:0] LEN_B  = 2'b00;
  localparam logic [1:0] LEN_H  = 2'b01;
  localparam logic [1:0] LEN_W  = 2'b10;
  localparam logic [1:0] LEN_RSV = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10,
    S_DONE = 2'b11
  } lsu_state_t;

  function automatic logic [1:0] op_of(input logic [4:0] m);
    return m[4:3];
  endfunction

  function automatic logic sign_of(input logic [4:0] m);
    return m[2];
  endfunction

  function automatic logic [1:0] len_of(input logic [4:0] m);
    return m[1:0];
  endfunction

  // Only real reads/writes of a defined length touch memory; everything else is a no-op.
  function automatic logic op_active(input logic [4:0] m);
    return ((op_of(m) == OP_RD) || (op_of(m) == OP_WR)) && (len_of(m) != LEN_RSV)
           && (op_of(m) != OP_NOP);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for a 32-bit word port: strobes, store replication,
// load extraction with sign/zero extension, and misalignment detect.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  len_i,
  input  logic        sign_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misaligned_o
);

  logic [31:0] rsh;

  // Strobes, replicated store data and alignment check for the request side.
  always_comb begin
    be_o         = 4'b0000;
    wdata_o      = wdata_i;
    misaligned_o = 1'b0;
    case (len_i)
      LEN_B: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      LEN_H: begin
        be_o         = 4'b0011 << addr_lo_i;
        wdata_o      = {2{wdata_i[15:0]}};
        misaligned_o = addr_lo_i[0];
      end
      LEN_W: begin
        be_o         = 4'b1111;
        misaligned_o = |addr_lo_i;
      end
      default: ;
    endcase
  end

  // Shift the addressed lane down to bit 0, then extend to 32 bits.
  always_comb begin
    rsh     = rdata_i >> {addr_lo_i, 3'b000};
    rdata_o = rsh;
    case (len_i)
      LEN_B:   rdata_o = {{24{sign_i & rsh[7]}}, rsh[7:0]};
      LEN_H:   rdata_o = {{16{sign_i & rsh[15]}}, rsh[15:0]};
      default: rdata_o = rsh;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// MEM-stage load/store unit: drives the word-wide data memory handshake and
// stalls the pipeline while an access is outstanding.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [4:0]        mem_op,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  output logic              lsu_stall,
  output logic              lsu_done,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              lsu_misaligned,
  output logic              dmem_req,
  input  logic              dmem_gnt,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata
);

  lsu_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        len_q, len_d;
  logic              sign_q, sign_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              mis_q, mis_d;

  logic [1:0]        al_addr_lo;
  logic [1:0]        al_len;
  logic              al_sign;
  logic [3:0]        al_be;
  logic [DATA_W-1:0] al_wdata;
  logic [DATA_W-1:0] al_rdata;
  logic              al_mis;

  // In IDLE the aligner looks at the incoming command; afterwards at the latched one.
  always_comb begin
    al_addr_lo = addr_q[1:0];
    al_len     = len_q;
    al_sign    = sign_q;
    if (state_q == S_IDLE) begin
      al_addr_lo = ex_addr[1:0];
      al_len     = len_of(mem_op);
      al_sign    = sign_of(mem_op);
    end
  end

  lsu_align u_align (
    .addr_lo_i    (al_addr_lo),
    .len_i        (al_len),
    .sign_i       (al_sign),
    .wdata_i      (ex_wdata),
    .rdata_i      (dmem_rdata),
    .be_o         (al_be),
    .wdata_o      (al_wdata),
    .rdata_o      (al_rdata),
    .misaligned_o (al_mis)
  );

  // Next-state, registered-output updates and stall/done decode.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    sign_d    = sign_q;
    req_d     = req_q;
    we_d      = we_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    mis_d     = mis_q;
    lsu_stall = 1'b0;
    lsu_done  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ex_valid && op_active(mem_op)) begin
          lsu_stall = 1'b1;
          if (al_mis) begin
            // Misaligned: report immediately, never touch memory.
            state_d = S_DONE;
            mis_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = S_REQ;
            addr_d  = ex_addr;
            len_d   = len_of(mem_op);
            sign_d  = sign_of(mem_op);
            req_d   = 1'b1;
            we_d    = (op_of(mem_op) == OP_WR);
            be_d    = al_be;
            wdata_d = al_wdata;
            rdata_d = '0;
            mis_d   = 1'b0;
          end
        end
      end
      S_REQ: begin
        lsu_stall = 1'b1;
        if (dmem_gnt) begin
          req_d   = 1'b0;
          state_d = we_q ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        lsu_stall = 1'b1;
        if (dmem_rvalid) begin
          rdata_d = al_rdata;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        lsu_done = 1'b1;
        mis_d    = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and memory-port registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= LEN_B;
      sign_q  <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= 4'b0000;
      wdata_q <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      sign_q  <= sign_d;
      req_q   <= req_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
    end
  end

  assign dmem_req       = req_q;
  assign dmem_we        = we_q;
  assign dmem_addr      = {addr_q[ADDR_W-1:2], 2'b00};
  assign dmem_be        = be_q;
  assign dmem_wdata     = wdata_q;
  assign lsu_rdata      = rdata_q;
  assign lsu_misaligned = mis_q;

endmodule

// File: tb/tb_lsu.sv
// Directed scoreboard bench for lsu: a driver issues commands and pushes the
// expected bus transaction / completion; a monitor compares as the DUT presents them.
module tb_lsu;

  logic        clk, rst;
  logic        ex_valid;
  logic [4:0]  mem_op;
  logic [31:0] ex_addr, ex_wdata;
  logic        lsu_stall, lsu_done, lsu_misaligned;
  logic [31:0] lsu_rdata;
  logic        dmem_req, dmem_gnt, dmem_we, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;

  lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .mem_op(mem_op),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .lsu_stall(lsu_stall),
    .lsu_done(lsu_done), .lsu_rdata(lsu_rdata), .lsu_misaligned(lsu_misaligned),
    .dmem_req(dmem_req), .dmem_gnt(dmem_gnt), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  typedef struct { logic mis; logic chk_rd; logic [31:0] rdata; } done_t;
  typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic chk_wd; logic [31:0] wdata; } bus_t;

  done_t done_q[$];
  bus_t  bus_q[$];
  int    tests = 0;
  int    fails = 0;

  // memory responder knobs
  int          gnt_delay = 0;
  int          rv_delay  = 0;
  logic [31:0] rd_word   = 32'h0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_done(input logic mis, input logic chk_rd, input logic [31:0] rdata);
    done_t d;
    d.mis = mis; d.chk_rd = chk_rd; d.rdata = rdata;
    done_q.push_back(d);
  endtask

  task automatic exp_bus(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic chk_wd, input logic [31:0] wdata);
    bus_t b;
    b.we = we; b.addr = addr; b.be = be; b.chk_wd = chk_wd; b.wdata = wdata;
    bus_q.push_back(b);
  endtask

  // Present one command and hold it until the DUT releases the stall; lat is
  // the expected number of stalled cycles before release.
  task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input int lat);
    int n;
    @(negedge clk);
    ex_valid = 1'b1; mem_op = op; ex_addr = addr; ex_wdata = wdata;
    n = 0;
    #1;
    while (lsu_stall && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({name, "_latency"}, 32'(n), 32'(lat));
    chk({name, "_done_on_release"}, {31'b0, lsu_done}, {31'b0, (lat > 0)});
  endtask

  // Data memory model: grant after gnt_delay request cycles, read data rv_delay cycles after grant.
  initial begin
    int  gcnt, rcnt;
    bit  rv_pend;
    gcnt = 0; rcnt = 0; rv_pend = 0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
      if (rv_pend) begin
        if (rcnt >= rv_delay) begin
          dmem_rvalid = 1'b1; dmem_rdata = rd_word; rv_pend = 0;
        end else rcnt++;
      end else if (dmem_req) begin
        if (gcnt >= gnt_delay) begin
          dmem_gnt = 1'b1; gcnt = 0;
          rv_pend = !dmem_we; rcnt = 0;
        end else gcnt++;
      end
    end
  end

  // Monitor: bus requests against the expected-transaction queue, completions against the done queue.
  initial begin
    bit    prev_done;
    done_t d;
    bus_t  b;
    prev_done = 0;
    forever begin
      @(negedge clk);
      #2;
      if (dmem_req) begin
        if (bus_q.size() == 0) chk("unexpected_req", {31'b0, dmem_req}, 32'd0);
        else begin
          b = bus_q[0];
          chk("bus_we", {31'b0, dmem_we}, {31'b0, b.we});
          chk("bus_addr", dmem_addr, b.addr);
          chk("bus_be", {28'b0, dmem_be}, {28'b0, b.be});
          if (b.chk_wd) chk("bus_wdata", dmem_wdata, b.wdata);
          if (dmem_gnt) void'(bus_q.pop_front());
        end
      end
      if (lsu_done) begin
        chk("done_not_back_to_back", {31'b0, prev_done}, 32'd0);
        if (done_q.size() == 0) chk("unexpected_done", {31'b0, lsu_done}, 32'd0);
        else begin
          d = done_q.pop_front();
          chk("misaligned", {31'b0, lsu_misaligned}, {31'b0, d.mis});
          if (d.chk_rd) chk("rdata", lsu_rdata, d.rdata);
        end
      end
      prev_done = lsu_done;
    end
  end

  initial begin
    rst = 1'b1; ex_valid = 1'b0; mem_op = 5'b0; ex_addr = 32'h0; ex_wdata = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req", {31'b0, dmem_req}, 32'd0);
    chk("rst_we", {31'b0, dmem_we}, 32'd0);
    chk("rst_be", {28'b0, dmem_be}, 32'd0);
    chk("rst_done", {31'b0, lsu_done}, 32'd0);
    chk("rst_mis", {31'b0, lsu_misaligned}, 32'd0);
    chk("rst_rdata", lsu_rdata, 32'd0);
    chk("rst_stall", {31'b0, lsu_stall}, 32'd0);
    rst = 1'b0;

    // store byte to lane 3
    exp_bus(1, 32'h1000, 4'b1000, 1, 32'hA5A5A5A5); exp_done(0, 0, 0);
    run_op("sb", 5'b10000, 32'h1003, 32'h000000A5, 2);
    // signed / unsigned half from upper lanes
    rd_word = 32'h80FF1234;
    exp_bus(0, 32'h2000, 4'b1100, 0, 0); exp_done(0, 1, 32'hFFFF80FF);
    run_op("lh", 5'b01101, 32'h2002, 32'h0, 3);
    exp_bus(0, 32'h2000, 4'b1100, 0, 0); exp_done(0, 1, 32'h000080FF);
    run_op("lhu", 5'b01001, 32'h2002, 32'h0, 3);
    // word load with grant held off 3 cycles
    gnt_delay = 3; rd_word = 32'hDEADBEEF;
    exp_bus(0, 32'h4008, 4'b1111, 0, 0); exp_done(0, 1, 32'hDEADBEEF);
    run_op("lw_slow", 5'b01010, 32'h4008, 32'h0, 6);
    gnt_delay = 0;
    // misaligned word: no request, zero data
    exp_done(1, 1, 32'h0);
    run_op("lw_mis", 5'b01010, 32'h3001, 32'h0, 1);
    // no-op, op=11, length=11
    run_op("nop", 5'b00010, 32'h0100, 32'h0, 0);
    run_op("op11", 5'b11010, 32'h0100, 32'h0, 0);
    run_op("len11_rd", 5'b01011, 32'h0100, 32'h0, 0);
    run_op("len11_wr", 5'b10011, 32'h0100, 32'h0, 0);
    // store half, load byte signed/unsigned
    exp_bus(1, 32'h5000, 4'b1100, 1, 32'hABCDABCD); exp_done(0, 0, 0);
    run_op("sh", 5'b10001, 32'h5002, 32'h1234ABCD, 2);
    rd_word = 32'h11228833;
    exp_bus(0, 32'h6000, 4'b0010, 0, 0); exp_done(0, 1, 32'hFFFFFF88);
    run_op("lb", 5'b01100, 32'h6001, 32'h0, 3);
    rd_word = 32'h9ABCDEF0;
    exp_bus(0, 32'h6000, 4'b1000, 0, 0); exp_done(0, 1, 32'h0000009A);
    run_op("lbu", 5'b01000, 32'h6003, 32'h0, 3);
    // store word, then one with a delayed grant
    exp_bus(1, 32'h7000, 4'b1111, 1, 32'hCAFEF00D); exp_done(0, 0, 0);
    run_op("sw", 5'b10010, 32'h7000, 32'hCAFEF00D, 2);
    gnt_delay = 2;
    exp_bus(1, 32'h7004, 4'b1111, 1, 32'h01234567); exp_done(0, 0, 0);
    run_op("sw_slow", 5'b10010, 32'h7004, 32'h01234567, 4);
    gnt_delay = 0;
    // misaligned stores
    exp_done(1, 1, 32'h0);
    run_op("sh_mis", 5'b10001, 32'h7003, 32'hFFFF, 1);
    exp_done(1, 1, 32'h0);
    run_op("sw_mis", 5'b10010, 32'h7002, 32'hFFFF, 1);

    // reset while waiting for read data; the late rvalid must be discarded
    rv_delay = 3; rd_word = 32'h55AA55AA;
    exp_bus(0, 32'h8004, 4'b1111, 0, 0);
    @(negedge clk); ex_valid = 1'b1; mem_op = 5'b01010; ex_addr = 32'h8004;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("wait_stall", {31'b0, lsu_stall}, 32'd1);
    rst = 1'b1; ex_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_mid_stall", {31'b0, lsu_stall}, 32'd0);
    chk("rst_mid_req", {31'b0, dmem_req}, 32'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("late_rvalid_no_done", {31'b0, lsu_done}, 32'd0);
    chk("late_rvalid_rdata", lsu_rdata, 32'd0);
    rv_delay = 0;

    // recovery after reset
    rd_word = 32'h0000007F;
    exp_bus(0, 32'h9000, 4'b0001, 0, 0); exp_done(0, 1, 32'h0000007F);
    run_op("lb_after_rst", 5'b01100, 32'h9000, 32'h0, 3);

    @(negedge clk); ex_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("done_q_drained", 32'(done_q.size()), 32'd0);
    chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit of the 5-stage RISC-V pipeline, sitting in the MEM stage. It consumes the 5-bit `mem_op` command generated at decode, plus the ALU-computed address and rs2 store data. It runs the handshake with the word-wide data memory port: byte-lane steering, strobes and load sign/zero extension. It stalls the pipeline while an access is outstanding.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width
- `DATA_W`, 32, data width; fixed at 32, four byte lanes

Ports:
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `ex_valid`  in  1  MEM-stage instruction valid; inputs stable while `lsu_stall`=1
- `mem_op`  in  5  [4:3] op: 00 no-op, 01 read, 10 write; [2] sign: 1 signed; [1:0] length: 00 byte, 01 half, 10 word
- `ex_addr`  in  ADDR_W  byte address
- `ex_wdata`  in  32  store data, LSB-aligned
- `lsu_stall`  out  1  hold pipeline
- `lsu_done`  out  1  one-cycle completion pulse
- `lsu_rdata`  out  32  extended load result, valid with `lsu_done`
- `lsu_misaligned`  out  1  misaligned access, valid with `lsu_done`
- `dmem_req`  out  1  request
- `dmem_gnt`  in  1  request accepted
- `dmem_we`  out  1  1 = write
- `dmem_addr`  out  ADDR_W  word-aligned: {ex_addr[ADDR_W-1:2],2'b00}
- `dmem_be`  out  4  byte strobes
- `dmem_wdata`  out  32  lane-replicated store data
- `dmem_rvalid`  in  1  read data valid
- `dmem_rdata`  in  32  read word

## Operation
- FSM states are IDLE, REQ, WAIT, DONE.
- IDLE:
  - `ex_valid` & op∈{01,10} & aligned → REQ, latching addr, wdata, op.
  - `ex_valid` & op∈{01,10} & misaligned → DONE with misaligned flag set.
  - Otherwise stay in IDLE.
- REQ: `dmem_req`=1 held until `dmem_gnt`. A granted write goes to DONE; a granted read goes to WAIT.
- WAIT: on `dmem_rvalid`, capture the extended data and go to DONE. `dmem_rvalid` in IDLE/REQ/DONE is ignored.
- DONE: `lsu_done`=1, then IDLE.
- Alignment: half requires addr[0]=0; word requires addr[1:0]=0; byte is always aligned. Length 11 and op 11 are treated as no-op: no stall, no done.
- Strobes:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<addr[1:0]
  - word: 4'b1111
  - read: same strobe, informational
- Write data: byte replicated ×4, half replicated ×2, word passed through.
- Read data: `dmem_rdata >> (8*addr[1:0])`, take the low 8/16/32 bits, then sign- or zero-extend per [2].
- Misaligned: no `dmem_req` ever issued; `lsu_rdata`=0.
- `lsu_stall` = (IDLE & `ex_valid` & valid op) | REQ | WAIT. It is 0 in DONE, so the pipeline advances on the done cycle.

## Timing
- Reset values: state IDLE; `dmem_req`, `dmem_we`, `lsu_done`, `lsu_misaligned`=0; `dmem_be`=0; `lsu_rdata`=0; `lsu_stall`=0 absent `ex_valid`.
- `dmem_*` outputs are registered from REQ entry and remain stable while `dmem_req`=1 and not granted.
- Best-case read takes 4 cycles (IDLE, REQ+gnt, WAIT+rvalid next cycle, DONE). Best-case write takes 3 cycles. Misaligned access takes 2 cycles.
- `dmem_rvalid` is allowed in the same cycle as the WAIT entry edge only from the cycle after the grant. Same-cycle gnt+rvalid is not supported.
- `rst` mid-operation: next cycle is IDLE and `dmem_req` drops. A late `dmem_rvalid` is discarded.
- `lsu_done` is never asserted for two consecutive cycles.

## Structure
- Package `lsu_pkg`:
  - `mem_op` field slices, op/sign/length constants shared with decode
  - `lsu_state_t` enum
- Sub-module `lsu_align`: purely combinational strobe generation, write replication, read extraction/extension and misalignment detect. The FSM stays in `lsu`.

## Test plan
- Store byte: addr 0x1003, wdata 0xA5, gnt immediate → `dmem_addr` 0x1000, `dmem_be` 4'b1000, `dmem_wdata` 0xA5A5A5A5, done at cycle 2.
- Load signed half: addr 0x2002, rdata 0x80FF1234, rvalid one cycle after grant → `lsu_rdata` 0xFFFF80FF. The unsigned variant gives 0x000080FF.
- Load word: gnt delayed 3 cycles → `dmem_req` and address held stable, `lsu_stall` high throughout, single done pulse.
- Misaligned word: addr 0x3001 → no `dmem_req`, `lsu_misaligned`=1 with done on cycle 1, `lsu_rdata` 0.
- No-op and op=11: `lsu_stall` stays 0, no done pulse, no request.
- `rst` asserted in WAIT → IDLE next cycle, subsequent `dmem_rvalid` produces no done.
